// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned TIMEOUT_DEF = 15;
    localparam logic [DATA_W-1:0] ERR_DATA = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RESP    = 2'd3
    } state_t;

    // Command presented to the shared memory while a port is being served.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between a fetch port
// and a data port, with a per-access timeout and sticky bus error.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err,
    output logic              bus_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    mem_cmd_t           cmd_q, cmd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_d_q, last_d_d;   // 1 when the last grant went to data
    logic               mem_req_q, mem_req_d;
    logic [DATA_W-1:0]  i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;
    logic               i_ack_q, i_ack_d;
    logic               d_ack_q, d_ack_d;
    logic               err_q, err_d;
    logic               bus_err_q, bus_err_d;

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            cnt_q     <= '0;
            last_d_q  <= 1'b0;
            mem_req_q <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            err_q     <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            cnt_q     <= cnt_d;
            last_d_q  <= last_d_d;
            mem_req_q <= mem_req_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            err_q     <= err_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Arbitration, wait counting and completion handling.
    always_comb begin
        logic grant_d;
        logic is_read;
        logic done;
        logic timed_out;
        logic [DATA_W-1:0] rd_val;

        state_d   = state_q;
        cmd_d     = cmd_q;
        cnt_d     = cnt_q;
        last_d_d  = last_d_q;
        mem_req_d = mem_req_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        err_d     = 1'b0;
        bus_err_d = bus_err_q;
        grant_d   = 1'b0;
        is_read   = (state_q == SERVE_I) || !cmd_q.we;
        done      = 1'b0;
        timed_out = 1'b0;
        rd_val    = mem_rdata;

        unique case (state_q)
            IDLE: begin
                grant_d = d_req && (!i_req || !last_d_q);
                if (grant_d) begin
                    state_d   = SERVE_D;
                    cmd_d     = '{we: d_we, addr: d_addr, wdata: d_wdata};
                    last_d_d  = 1'b1;
                    cnt_d     = '0;
                    mem_req_d = 1'b1;
                end else if (i_req) begin
                    state_d   = SERVE_I;
                    cmd_d     = '{we: 1'b0, addr: i_addr, wdata: '0};
                    last_d_d  = 1'b0;
                    cnt_d     = '0;
                    mem_req_d = 1'b1;
                end
            end
            SERVE_I, SERVE_D: begin
                if (!mem_ack && cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // An ack landing on the final counted cycle still wins.
                if (mem_ack) begin
                    done = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    done      = 1'b1;
                    timed_out = 1'b1;
                    rd_val    = ERR_DATA;
                end
                if (done) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    err_d     = timed_out;
                    bus_err_d = bus_err_q | timed_out;
                    if (state_q == SERVE_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = rd_val;
                    end else begin
                        d_ack_d = 1'b1;
                        if (is_read) begin
                            d_rdata_d = rd_val;
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign err       = err_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model,
// per-cycle compare, and directed scenarios with literal expectations.
module tb_mem_arbiter;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic [15:0] i_rdata;
    logic        i_ack;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic [15:0] d_rdata;
    logic        d_ack;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        err;
    logic        bus_err;

    int tests = 0;
    int fails = 0;

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .err(err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        return (a == 16'h0010) ? 16'h1234 : 16'(a * 16'd3 + 16'h0101);
    endfunction

    // Memory responder: ack after ack_delay cycles of mem_req (0 = never).
    int ack_delay = 1;
    bit spur = 1'b0;
    initial begin
        int rcnt;
        rcnt = 0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (spur) begin
                mem_ack   = 1'b1;
                mem_rdata = 16'hDEAD;
            end else if (mem_req) begin
                rcnt++;
                if (ack_delay > 0 && rcnt == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_val(mem_addr);
                end
            end else begin
                rcnt = 0;
            end
        end
    end

    // Reference model: one outstanding access, round-robin on contention,
    // completion on ack or after TIMEOUT unanswered serve cycles.
    logic        exp_mem_req, exp_we, exp_i_ack, exp_d_ack, exp_err, exp_bus_err;
    logic [15:0] exp_addr, exp_wdata, exp_i_rdata, exp_d_rdata;
    int m_port, m_last, m_age;
    bit m_resp;
    initial begin
        int pick;
        logic [15:0] val;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                exp_mem_req = 0; exp_we = 0; exp_i_ack = 0; exp_d_ack = 0;
                exp_err = 0; exp_bus_err = 0; exp_addr = 0; exp_wdata = 0;
                exp_i_rdata = 0; exp_d_rdata = 0;
                m_port = 0; m_last = 1; m_age = 0; m_resp = 0;
            end else begin
                exp_i_ack = 0; exp_d_ack = 0; exp_err = 0;
                if (m_resp) begin
                    m_resp = 0;
                end else if (m_port == 0) begin
                    pick = 0;
                    if (i_req && d_req) pick = (m_last == 1) ? 2 : 1;
                    else if (i_req)     pick = 1;
                    else if (d_req)     pick = 2;
                    if (pick != 0) begin
                        m_port = pick; m_last = pick; m_age = 0;
                        exp_mem_req = 1;
                        exp_addr  = (pick == 1) ? i_addr : d_addr;
                        exp_we    = (pick == 2) && d_we;
                        exp_wdata = d_wdata;
                    end
                end else begin
                    m_age++;
                    if (mem_ack || m_age == TIMEOUT) begin
                        val = mem_ack ? mem_rdata : 16'hFFFF;
                        exp_mem_req = 0;
                        if (m_port == 1) begin
                            exp_i_ack = 1; exp_i_rdata = val;
                        end else begin
                            exp_d_ack = 1;
                            if (!exp_we) exp_d_rdata = val;
                        end
                        if (!mem_ack) begin
                            exp_err = 1; exp_bus_err = 1;
                        end
                        m_port = 0; m_resp = 1;
                    end
                end
            end
        end
    end

    // Per-cycle compare, plus a log of addresses at each new memory request.
    logic [15:0] addr_log[$];
    initial begin
        logic prev_req;
        prev_req = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!reset) begin
                chk("mem_req", 32'(mem_req), 32'(exp_mem_req));
                chk("i_ack", 32'(i_ack), 32'(exp_i_ack));
                chk("d_ack", 32'(d_ack), 32'(exp_d_ack));
                chk("err", 32'(err), 32'(exp_err));
                chk("bus_err", 32'(bus_err), 32'(exp_bus_err));
                chk("i_rdata", 32'(i_rdata), 32'(exp_i_rdata));
                chk("d_rdata", 32'(d_rdata), 32'(exp_d_rdata));
                if (exp_mem_req) begin
                    chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
                    chk("mem_we", 32'(mem_we), 32'(exp_we));
                    if (exp_we) chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
                end
                if (mem_req && !prev_req) addr_log.push_back(mem_addr);
            end
            prev_req = mem_req;
        end
    end

    task automatic wait_ack(input int budget, output int port);
        port = 0;
        for (int n = 0; n < budget && port == 0; n++) begin
            @(negedge clk);
            if (d_ack) port = 2;
            else if (i_ack) port = 1;
        end
        if (port == 0) begin
            tests++;
            fails++;
            $display("FAIL ack_wait: no ack within %0d cycles", budget);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int p;
        int nreq;
        int order[4];
        order[0] = 2; order[1] = 1; order[2] = 2; order[3] = 1;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_i_rdata", 32'(i_rdata), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);

        // Fetch only: mem_ack at cycle 3, ack at cycle 4.
        ack_delay = 3;
        i_addr = 16'h0010; i_req = 1'b1;
        @(negedge clk);
        chk("f_mem_req_c1", 32'(mem_req), 32'd1);
        chk("f_mem_addr_c1", 32'(mem_addr), 32'h0010);
        chk("f_mem_we_c1", 32'(mem_we), 32'd0);
        repeat (2) @(negedge clk);
        chk("f_i_ack_c3", 32'(i_ack), 32'd0);
        @(negedge clk);
        chk("f_i_ack_c4", 32'(i_ack), 32'd1);
        chk("f_i_rdata_c4", 32'(i_rdata), 32'h1234);
        chk("f_d_ack_c4", 32'(d_ack), 32'd0);
        chk("f_mem_req_c4", 32'(mem_req), 32'd0);
        i_req = 1'b0;
        @(negedge clk);
        chk("f_i_ack_c5", 32'(i_ack), 32'd0);

        // Contention after reset: data first, then alternating.
        do_reset();
        addr_log.delete();
        ack_delay = 1;
        i_addr = 16'h0100; d_addr = 16'h0200; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(10, p);
            chk("rr_order", 32'(p), 32'(order[k]));
        end
        i_req = 1'b0; d_req = 1'b0;
        chk("rr_nlog", 32'(addr_log.size()), 32'd4);
        if (addr_log.size() >= 2) begin
            chk("rr_addr0", 32'(addr_log[0]), 32'h0200);
            chk("rr_addr1", 32'(addr_log[1]), 32'h0100);
        end
        chk("rr_i_rdata", 32'(i_rdata), 32'h0401);
        chk("rr_d_rdata", 32'(d_rdata), 32'h0701);

        // Store: write command held until ack, d_rdata untouched.
        @(negedge clk);
        ack_delay = 4;
        d_we = 1'b1; d_addr = 16'h00FF; d_wdata = 16'hBEEF; d_req = 1'b1;
        @(negedge clk);
        chk("st_mem_we", 32'(mem_we), 32'd1);
        chk("st_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        wait_ack(10, p);
        chk("st_port", 32'(p), 32'd2);
        chk("st_d_rdata", 32'(d_rdata), 32'h0701);
        d_req = 1'b0; d_we = 1'b0;

        // Ack on the last allowed cycle counts as success.
        @(negedge clk);
        ack_delay = TIMEOUT;
        d_addr = 16'h0300; d_req = 1'b1;
        wait_ack(30, p);
        chk("edge_err", 32'(err), 32'd0);
        chk("edge_d_rdata", 32'(d_rdata), 32'h0A01);
        d_req = 1'b0;

        // Timeout: no ack ever.
        @(negedge clk);
        ack_delay = 0;
        i_addr = 16'h0040; i_req = 1'b1;
        nreq = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (mem_req) nreq++;
            else break;
        end
        i_req = 1'b0;
        chk("to_req_cycles", 32'(nreq), 32'd15);
        chk("to_i_ack", 32'(i_ack), 32'd1);
        chk("to_err", 32'(err), 32'd1);
        chk("to_i_rdata", 32'(i_rdata), 32'hFFFF);
        chk("to_bus_err", 32'(bus_err), 32'd1);

        // Normal access afterwards; bus_err stays set.
        @(negedge clk);
        ack_delay = 2;
        d_addr = 16'h0010; d_req = 1'b1;
        wait_ack(10, p);
        d_req = 1'b0;
        chk("post_err", 32'(err), 32'd0);
        chk("post_d_rdata", 32'(d_rdata), 32'h1234);
        chk("post_bus_err", 32'(bus_err), 32'd1);

        // Stray acks while idle are ignored.
        spur = 1'b1;
        repeat (3) @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        chk("spur_i_rdata", 32'(i_rdata), 32'hFFFF);
        chk("spur_d_rdata", 32'(d_rdata), 32'h1234);

        // Reset two cycles into a data access.
        ack_delay = 0;
        d_addr = 16'h0050; d_req = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1; d_req = 1'b0;
        #1;
        chk("rs_mem_req", 32'(mem_req), 32'd0);
        chk("rs_d_ack", 32'(d_ack), 32'd0);
        repeat (2) @(negedge clk);
        chk("rs_bus_err", 32'(bus_err), 32'd0);
        chk("rs_d_rdata", 32'(d_rdata), 32'd0);
        reset = 1'b0;
        ack_delay = 2;
        @(negedge clk);
        i_addr = 16'h0100; i_req = 1'b1;
        wait_ack(10, p);
        i_req = 1'b0;
        chk("rs_port", 32'(p), 32'd1);
        chk("rs_i_rdata", 32'(i_rdata), 32'h0401);
        chk("rs_err", 32'(err), 32'd0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
